uart_rx_fifo: RTL
=================

# uart_rx_fifo

Receive buffer between the UART receiver and the consuming logic. Captures each byte the receiver presents with its one-cycle done strobe and holds up to 2^ADDR_W bytes in first-in-first-out order. Presents the head byte to the consumer in first-word-fall-through style. Reports occupancy and a sticky overflow flag for bytes lost while full.

## Interface
- DATA_W, 8: byte width; matches the receiver data output.
- ADDR_W, 4: log2 of depth; default depth is 16 entries.
- AF_LEVEL, 12: almost-full threshold in entries. Used only with the configuration macro.

- clk, input, 1: single clock; all state changes on the rising edge.
- reset, input, 1: synchronous, active-low reset; sampled on the rising edge of clk.
- rx_done_tick, input, 1: one-cycle write strobe from the receiver.
- din, input, DATA_W: byte to store; valid while rx_done_tick=1.
- rd_en, input, 1: consumer pops the head entry this cycle.
- ovf_clr, input, 1: clears the sticky overflow flag.
- dout, output, DATA_W: head entry; 0 while empty.
- empty, output, 1: no entries stored.
- full, output, 1: count equals 2^ADDR_W.
- count, output, ADDR_W+1: number of stored entries, 0 to 2^ADDR_W.
- overflow, output, 1: sticky flag; a byte was dropped.
- almost_full, output, 1: present only with UART_RX_FIFO_ALMOST_FULL_EN.

## Operation
- Storage is a 2^ADDR_W x DATA_W register array, not reset.
- Write pointer and read pointer are ADDR_W bits each and wrap modulo depth naturally. count is tracked in its own ADDR_W+1-bit register.
- Write is accepted when rx_done_tick=1 and either:
  - full=0, or
  - full=1 and rd_en=1 in the same cycle.
- On an accepted write: mem[wr_ptr]<=din and wr_ptr increments.
- Read is accepted when rd_en=1 and empty=0. rd_ptr increments.
- rd_en while empty is ignored; there is no underflow flag and no state change.
- count update per cycle:
  - +1 for write only.
  - -1 for read only.
  - Unchanged for both or neither.
- empty is derived as count==0 and full as count==2^ADDR_W, both registered with count.
- Simultaneous write and read while empty: the read is ignored and the write is accepted, so count becomes 1.
- Simultaneous write and read while full: both happen, count stays 2^ADDR_W, and overflow is not set.
- Overflow set condition: rx_done_tick=1, full=1, rd_en=0. The byte is dropped and pointers are unchanged.
- Overflow clear: ovf_clr=1. If set and clear occur in the same cycle, set wins and overflow remains 1.
- dout = mem[rd_ptr] when empty=0, else 0. This is a combinational read of the array.

## Timing
- Reset values after a rising edge with reset=0: pointers 0, count 0, empty 1, full 0, overflow 0, dout 0, almost_full 0.
- Reset mid-operation discards all stored entries.
- Write latency: a byte written at edge N is visible on dout at edge N when the FIFO was empty, with empty=0 and count=1 after edge N.
- Read: the consumer samples dout in the cycle rd_en=1. The next entry (or 0 if that was the last) appears after that edge.
- Status flags and count change only on clock edges; there are no combinational paths from the inputs to them.
- Back-to-back strobes on consecutive cycles are accepted at full rate, one byte per cycle.

## Configuration
- Macro: UART_RX_FIFO_ALMOST_FULL_EN.
- Defined:
  - almost_full port exists.
  - almost_full is a registered flag, 1 when the next-state count is >= AF_LEVEL, updated on the same edge as count.
  - AF_LEVEL must be between 1 and 2^ADDR_W.
- Not defined:
  - Port and logic are absent.
  - AF_LEVEL is unused.
  - All other behaviour is identical.

## Test plan
- Reset then idle: hold reset=0 for 2 cycles, release -> empty=1, full=0, count=0, overflow=0, dout=0.
- Single byte: rx_done_tick with din=8'hA5 -> next cycle empty=0, count=1, dout=8'hA5. rd_en one cycle -> empty=1, dout=0.
- Fill and wrap: write 16 bytes 0x00..0x0F -> full=1, count=16. Read 8 and write 0x10..0x17, then drain all 16 -> order 0x08..0x17.
- Overflow: when full, strobe din=8'hEE with rd_en=0 -> overflow=1, count=16, 0xEE never appears. ovf_clr with a simultaneous second drop -> overflow stays 1. ovf_clr alone -> overflow=0.
- Simultaneous events:
  - Full, with rx_done_tick and rd_en together, din=8'h55 -> count stays 16, overflow=0, 0x55 emerges last.
  - Empty, with rd_en and rx_done_tick together -> count=1.
- Almost-full, with macro defined and AF_LEVEL=12: the 12th write raises almost_full after its edge. One read at count 12 lowers it.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// ------------
// Receive buffer between a UART receiver and its consumer. Each byte the
// receiver presents with its one-cycle done strobe is stored in a
// 2^ADDR_W-deep first-in-first-out array. The head byte is presented
// first-word-fall-through on dout (0 while empty). Occupancy, empty/full
// status and a sticky overflow flag are all registered.
//
// Optional feature macro: UART_RX_FIFO_ALMOST_FULL_EN
//   When defined, adds a registered almost_full output that is 1 whenever the
//   stored count is >= AF_LEVEL (1 .. 2^ADDR_W). When undefined the port and its
//   logic are absent and AF_LEVEL is unused.
//
// Parameters
//   DATA_W    byte width
//   ADDR_W    log2 of the depth
//   AF_LEVEL  almost-full threshold in entries (macro builds only)
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-low reset
//   rx_done_tick  one-cycle write strobe from the receiver
//   din           byte to store, valid with rx_done_tick
//   rd_en         consumer pops the head entry this cycle
//   ovf_clr       clears the sticky overflow flag
//   dout          head entry, 0 while empty
//   empty         no entries stored
//   full          count equals 2^ADDR_W
//   count         number of stored entries, 0 .. 2^ADDR_W
//   overflow      sticky: a byte was dropped while full
//   almost_full   count >= AF_LEVEL (macro builds only)

module uart_rx_fifo #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned AF_LEVEL = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_done_tick,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  input  logic              ovf_clr,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  ,
  output logic              almost_full
`endif
);

  localparam int unsigned Depth = 1 << ADDR_W;

  // Count value that means "full": only the MSB of the ADDR_W+1-bit count set.
  localparam logic [ADDR_W:0] FullCnt = {1'b1, {ADDR_W{1'b0}}};

  // Storage array; deliberately not reset, empty masks its contents on dout.
  logic [DATA_W-1:0] mem [Depth];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              ovf_q, ovf_d;

  logic wr_acc;
  logic rd_acc;
  logic ovf_set;

  // A write is taken while not full, or while full if the head is popped in
  // the same cycle (the pop frees the slot the write lands in).
  assign wr_acc  = rx_done_tick & (~full_q | rd_en);
  // A pop while empty is ignored, even if a write arrives in the same cycle.
  assign rd_acc  = rd_en & ~empty_q;
  // A strobe while full with no pop loses the byte.
  assign ovf_set = rx_done_tick & full_q & ~rd_en;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
      default: count_d = count_q;
    endcase

    // Flags are computed from the next-state count so they register together.
    empty_d = (count_d == '0);
    full_d  = (count_d == FullCnt);

    // Set has priority over clear so a drop in the clearing cycle is not lost.
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
    end
  end

  // Array write. Gated by reset so a strobe during reset leaves no trace in
  // the pointer-addressed slot that will be written first afterwards.
  always_ff @(posedge clk) begin
    if (reset && wr_acc) begin
      mem[wr_ptr_q] <= din;
    end
  end

`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  localparam logic [ADDR_W:0] AfCnt = AF_LEVEL[ADDR_W:0];

  logic af_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      af_q <= 1'b0;
    end else begin
      af_q <= (count_d >= AfCnt);
    end
  end

  assign almost_full = af_q;
`endif

  // First-word-fall-through head: combinational array read, masked while empty.
  assign dout     = empty_q ? '0 : mem[rd_ptr_q];
  assign empty    = empty_q;
  assign full     = full_q;
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule
